// File: rtl/turn_signal_controller_pkg.sv
// Shared state encoding for the turn-signal controller and the light-path blocks.
package turn_signal_controller_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_LEFT   = 2'd1,
    ST_RIGHT  = 2'd2,
    ST_HAZARD = 2'd3
  } tsc_state_t;

  function automatic logic lamp_left_en(input tsc_state_t s);
    return (s == ST_LEFT) || (s == ST_HAZARD);
  endfunction

  function automatic logic lamp_right_en(input tsc_state_t s);
    return (s == ST_RIGHT) || (s == ST_HAZARD);
  endfunction

endpackage

// File: rtl/turn_signal_controller_btn_debounce.sv
// Button conditioning: 2-FF synchronizer, counting debouncer, one-cycle press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 10000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DCW-1:0] CNT_LAST = DCW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]     r_sync;
  logic           r_level;
  logic           r_press;
  logic [DCW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b00;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_press <= 1'b0;
      // Accept the new level only after it has disagreed for the full window.
      if (r_sync[1] != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_cnt   <= '0;
          r_level <= r_sync[1];
          r_press <= r_sync[1];
        end else begin
          r_cnt <= r_cnt + DCW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/turn_signal_controller.sv
// Turn-signal FSM (OFF/LEFT/RIGHT/HAZARD) with blink generator and registered lamp outputs.
module turn_signal_controller
  import turn_signal_controller_pkg::*;
#(
  parameter int HALF_PERIOD     = 500000,
  parameter int DEBOUNCE_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       sw_hazard,
  output logic       turn_left,
  output logic       turn_right,
  output logic       blink_click,
  output logic [1:0] mode
);

  localparam int CW = $clog2(HALF_PERIOD);
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_PERIOD - 1);

  tsc_state_t    r_state, r_saved_dir;
  logic [CW-1:0] r_cnt;
  logic          r_phase, r_turn_left, r_turn_right, r_click;
  logic [1:0]    r_haz_sync;

  tsc_state_t    w_state_nxt, w_saved_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_phase_nxt, w_click_nxt;
  logic          w_press_l, w_press_r, w_level_l, w_level_r;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk(clk), .rst_n(rst), .i_btn(btn_left), .o_level(w_level_l), .o_press(w_press_l)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk(clk), .rst_n(rst), .i_btn(btn_right), .o_level(w_level_r), .o_press(w_press_r)
  );

  // Hazard wins over buttons; presses seen while in HAZARD are simply dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_saved_nxt = r_saved_dir;
    if (r_state == ST_HAZARD) begin
      if (!r_haz_sync[1]) w_state_nxt = r_saved_dir;
    end else if (r_haz_sync[1]) begin
      w_state_nxt = ST_HAZARD;
      w_saved_nxt = r_state;
    end else begin
      case (r_state)
        ST_OFF: begin
          if (w_press_l && !w_press_r)      w_state_nxt = ST_LEFT;
          else if (w_press_r && !w_press_l) w_state_nxt = ST_RIGHT;
        end
        ST_LEFT: begin
          if (w_press_l)      w_state_nxt = ST_OFF;
          else if (w_press_r) w_state_nxt = ST_RIGHT;
        end
        ST_RIGHT: begin
          if (w_press_r)      w_state_nxt = ST_OFF;
          else if (w_press_l) w_state_nxt = ST_LEFT;
        end
        default: ;
      endcase
    end
  end

  // Entering an active state restarts the blink with the lamp ON and a click.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    w_click_nxt = 1'b0;
    if (w_state_nxt != r_state) begin
      w_cnt_nxt   = '0;
      w_phase_nxt = (w_state_nxt != ST_OFF);
      w_click_nxt = (w_state_nxt != ST_OFF);
    end else if (r_state == ST_OFF) begin
      w_cnt_nxt   = '0;
      w_phase_nxt = 1'b0;
    end else if (r_cnt == CNT_LAST) begin
      w_cnt_nxt   = '0;
      w_phase_nxt = ~r_phase;
      w_click_nxt = 1'b1;
    end else begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_OFF;
      r_saved_dir  <= ST_OFF;
      r_cnt        <= '0;
      r_phase      <= 1'b0;
      r_turn_left  <= 1'b0;
      r_turn_right <= 1'b0;
      r_click      <= 1'b0;
      r_haz_sync   <= 2'b00;
    end else begin
      r_haz_sync   <= {r_haz_sync[0], sw_hazard};
      r_state      <= w_state_nxt;
      r_saved_dir  <= w_saved_nxt;
      r_cnt        <= w_cnt_nxt;
      r_phase      <= w_phase_nxt;
      r_click      <= w_click_nxt;
      r_turn_left  <= w_phase_nxt && lamp_left_en(w_state_nxt);
      r_turn_right <= w_phase_nxt && lamp_right_en(w_state_nxt);
    end
  end

  assign turn_left   = r_turn_left;
  assign turn_right  = r_turn_right;
  assign blink_click = r_click;
  assign mode        = r_state;

endmodule

// File: tb/tb_turn_signal_controller.sv
// Scoreboard bench for turn_signal_controller with HALF_PERIOD=4, DEBOUNCE_CYCLES=3.
module tb_turn_signal_controller;

  localparam int HP = 4;
  localparam logic [1:0] M_OFF = 2'd0, M_LEFT = 2'd1, M_RIGHT = 2'd2, M_HAZ = 2'd3;

  logic clk = 1'b0;
  logic rst, btn_left, btn_right, sw_hazard;
  logic turn_left, turn_right, blink_click;
  logic [1:0] mode;

  typedef struct {
    int         cyc;
    logic [1:0] mode;
    logic       tl;
    logic       tr;
    logic       ck;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  turn_signal_controller #(.HALF_PERIOD(HP), .DEBOUNCE_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .btn_left(btn_left), .btn_right(btn_right),
    .sw_hazard(sw_hazard), .turn_left(turn_left), .turn_right(turn_right),
    .blink_click(blink_click), .mode(mode)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares outputs against expectations scheduled for this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      n_vec++; n_err++;
      $display("FAIL missed_vector cyc=%0d", exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      n_vec++;
      if (mode !== exp_q[0].mode || turn_left !== exp_q[0].tl ||
          turn_right !== exp_q[0].tr || blink_click !== exp_q[0].ck) begin
        n_err++;
        $display("FAIL outputs cyc=%0d mode/tl/tr/click got %0d/%b/%b/%b expected %0d/%b/%b/%b",
                 cyc, mode, turn_left, turn_right, blink_click,
                 exp_q[0].mode, exp_q[0].tl, exp_q[0].tr, exp_q[0].ck);
      end
      void'(exp_q.pop_front());
    end
  end

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog cyc=%0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [1:0] m, input logic tl, input logic tr, input logic ck);
    exp_t e;
    e.cyc = c; e.mode = m; e.tl = tl; e.tr = tr; e.ck = ck;
    exp_q.push_back(e);
  endtask

  task automatic push_zero(input int c0, input int c1);
    for (int c = c0; c <= c1; c++) push(c, M_OFF, 1'b0, 1'b0, 1'b0);
  endtask

  // Expected blink from state entry: ON for HP cycles, OFF for HP, click on every phase change.
  task automatic expect_blink(input int c0, input int len, input logic [1:0] m);
    logic ph;
    for (int k = 0; k < len; k++) begin
      ph = ((k / HP) % 2) == 0;
      push(c0 + k, m, ph && (m == M_LEFT || m == M_HAZ),
           ph && (m == M_RIGHT || m == M_HAZ), (k % HP) == 0);
    end
  endtask

  int c;

  initial begin
    rst = 1'b0; btn_left = 1'b0; btn_right = 1'b0; sw_hazard = 1'b0;
    step(3);
    c = cyc; push_zero(c + 1, c + 2);
    step(2);
    rst = 1'b1;

    // Basic left blink, one press, 20 cycles of LEFT (5 clicks)
    c = cyc; btn_left = 1'b1;
    push_zero(c + 1, c + 5);
    expect_blink(c + 6, 20, M_LEFT);
    step(10); btn_left = 1'b0; step(16);

    // Direction switch LEFT -> RIGHT
    c = cyc; btn_right = 1'b1;
    expect_blink(c + 6, 8, M_RIGHT);
    step(10); btn_right = 1'b0; step(4);

    // Hazard override, ignored left press, restore to RIGHT
    c = cyc; sw_hazard = 1'b1;
    expect_blink(c + 3, 12, M_HAZ);
    step(4); btn_left = 1'b1; step(8); btn_left = 1'b0; step(4);
    sw_hazard = 1'b0;
    expect_blink(c + 19, 8, M_RIGHT);
    step(11);

    // Right press in RIGHT -> OFF with no click
    c = cyc; btn_right = 1'b1;
    push_zero(c + 6, c + 7);
    step(10); btn_right = 1'b0; step(10);

    // Bounce rejection
    c = cyc;
    push_zero(c + 1, c + 20);
    for (int i = 0; i < 6; i++) begin
      btn_left = (i % 2) == 0;
      step(2);
    end
    btn_left = 1'b0; step(10);

    // Simultaneous presses in OFF
    c = cyc;
    push_zero(c + 1, c + 12);
    btn_left = 1'b1; btn_right = 1'b1;
    step(10); btn_left = 1'b0; btn_right = 1'b0; step(10);

    // Reset mid-blink in LEFT, then button held through reset release
    c = cyc; btn_left = 1'b1;
    expect_blink(c + 6, 8, M_LEFT);
    step(10); btn_left = 1'b0; step(4);
    rst = 1'b0; #1;
    n_vec++;
    if (mode !== 2'd0 || turn_left !== 1'b0 || turn_right !== 1'b0 || blink_click !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset mode/tl/tr/click got %0d/%b/%b/%b expected 0/0/0/0",
               mode, turn_left, turn_right, blink_click);
    end
    btn_left = 1'b1;
    step(3);
    rst = 1'b1;
    c = cyc;
    push_zero(c + 1, c + 5);
    expect_blink(c + 6, 4, M_LEFT);
    step(12); btn_left = 1'b0;

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) step(1);
    if (exp_q.size() > 0) begin
      n_vec++; n_err++;
      $display("FAIL drain pending=%0d expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
